// File: rtl/avmm_pio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : avmm_pio_initiator
// Summary  : Avalon-MM initiator for single-word PIO-style slaves. Turns a
//            valid/ready command into one Avalon transfer, returns a
//            one-cycle response pulse and registers the slave irq line.
// Options  : `define AVM_TIMEOUT_EN to abort transfers stuck on waitrequest
//            after TIMEOUT_CYCLES stalled cycles (response flags rsp_error).
// Revision : 1.0 - initial release
// ============================================================================
module avmm_pio_initiator #(
    parameter int ADDR_W         = 2,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       cmd_writedata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              irq_in,
    output logic              irq_level,
    output logic              irq_rise
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } state_t;

    // RWAIT counts down from READ_LATENCY-1; latency 0 never enters RWAIT.
    localparam logic [2:0] c_rl_init = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    // Out-of-range parameters would silently truncate counters; stop elaboration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
        READ_LATENCY < 0 || READ_LATENCY > 7) begin : g_param_check
        $error("avmm_pio_initiator: READ_LATENCY or TIMEOUT_CYCLES out of range");
    end

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [2:0]        r_lat_cnt;
    logic              r_irq_level;
    logic              r_irq_rise;
    logic              w_accept;
    logic              w_capture;
    logic              w_timeout;

    assign w_accept = cmd_valid && (r_state == IDLE);

`ifdef AVM_TIMEOUT_EN
    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_to_cnt;
    logic        r_err;

    // The stall that brings the count to TIMEOUT_CYCLES ends the transfer.
    assign w_timeout = avm_waitrequest && (r_to_cnt == c_to_last) &&
                       ((r_state == WR) || (r_state == RD));
    assign rsp_error = r_err;

    // Stall counter: cleared when a transfer starts, counts waitrequest cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= 16'd0;
        end else if (w_accept) begin
            r_to_cnt <= 16'd0;
        end else if (((r_state == WR) || (r_state == RD)) && avm_waitrequest) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    // Error flag: cleared per command, set when the transfer is aborted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and read-data capture strobe.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = cmd_write ? WR : RD;
                end
            end
            WR: begin
                if (w_timeout || !avm_waitrequest) begin
                    w_next = RESP;
                end
            end
            RD: begin
                if (w_timeout) begin
                    w_next = RESP;
                end else if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        w_capture = 1'b1;
                        w_next    = RESP;
                    end else begin
                        w_next = RWAIT;
                    end
                end
            end
            RWAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_capture = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Command capture, read-latency countdown and response data.
    // Address stays put through RWAIT since the slave's readdata follows it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_lat_cnt <= 3'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= cmd_address;
                r_wdata <= cmd_writedata;
                r_rdata <= 32'd0;
            end
            if ((r_state == RD) && !avm_waitrequest) begin
                r_lat_cnt <= c_rl_init;
            end else if (r_state == RWAIT) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end
            if (w_capture) begin
                r_rdata <= avm_readdata;
            end
        end
    end

    // irq synchroniser stage and rising-edge detect, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_level <= 1'b0;
            r_irq_rise  <= 1'b0;
        end else begin
            r_irq_level <= irq_in;
            r_irq_rise  <= irq_in & ~r_irq_level;
        end
    end

    assign cmd_ready      = (r_state == IDLE);
    assign rsp_valid      = (r_state == RESP);
    assign rsp_readdata   = r_rdata;
    assign avm_address    = r_addr;
    assign avm_writedata  = r_wdata;
    assign avm_chipselect = (r_state == WR) || (r_state == RD);
    assign avm_write_n    = (r_state != WR);
    assign irq_level      = r_irq_level;
    assign irq_rise       = r_irq_rise;

endmodule
`default_nettype wire

// File: tb/tb_avmm_pio_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_avmm_pio_initiator
// Summary  : Self-checking bench for avmm_pio_initiator with a registered
//            4-word slave model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avmm_pio_initiator;

    localparam int ADDR_W = 2;
    localparam int RL     = 1;
    localparam int TO     = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [31:0]       cmd_writedata;
    logic              rsp_valid;
    logic [31:0]       rsp_readdata;
    logic              rsp_error;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [31:0]       avm_writedata;
    logic [31:0]       sl_rdata;
    logic              wait_req;
    logic              irq_in;
    logic              irq_level;
    logic              irq_rise;

    rsp_t        sb[$];
    rsp_t        mon_exp;
    int          total    = 0;
    int          bad      = 0;
    int          rsp_seen = 0;
    logic [31:0] mem[4];
    logic [31:0] exp_mem[4];

    always #5 clk = ~clk;

    avmm_pio_initiator #(
        .ADDR_W         (ADDR_W),
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .cmd_writedata   (cmd_writedata),
        .rsp_valid       (rsp_valid),
        .rsp_readdata    (rsp_readdata),
        .rsp_error       (rsp_error),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (sl_rdata),
        .avm_waitrequest (wait_req),
        .irq_in          (irq_in),
        .irq_level       (irq_level),
        .irq_rise        (irq_rise)
    );

    function automatic logic [31:0] init_val(int i);
        return (i == 0) ? 32'h0000_00A5 : {8{4'(i)}};
    endfunction

    // Registered PIO slave: readdata follows the address one cycle late.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= init_val(i);
            sl_rdata <= 32'd0;
        end else begin
            if (avm_chipselect && !avm_write_n && !wait_req)
                mem[avm_address] <= avm_writedata;
            sl_rdata <= mem[avm_address];
        end
    end

    // Response monitor: every rsp_valid pops and checks the scoreboard.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            rsp_seen++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: got data=%h err=%b with no command pending",
                         rsp_readdata, rsp_error);
            end else begin
                mon_exp = sb.pop_front();
                if ({rsp_readdata, rsp_error} !== mon_exp) begin
                    bad++;
                    $display("FAIL rsp_payload: got data=%h err=%b, want data=%h err=%b",
                             rsp_readdata, rsp_error, mon_exp.data, mon_exp.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) exp_mem[i] = init_val(i);
    endtask

    task automatic drain(output int n);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        reset_model();
        repeat (2) tick();
        total++;
        if ({cmd_ready, rsp_valid, rsp_error, avm_chipselect, avm_write_n, irq_level, irq_rise} !== 7'b1000100) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 1000100",
                     {cmd_ready, rsp_valid, rsp_error, avm_chipselect, avm_write_n, irq_level, irq_rise});
        end
        total++;
        if ({rsp_readdata, avm_address, avm_writedata} !== '0) begin
            bad++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want all 0",
                     rsp_readdata, avm_address, avm_writedata);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if ({cmd_ready, avm_chipselect} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_idle: got ready/cs=%b want 10", {cmd_ready, avm_chipselect});
        end
    endtask

    task automatic test_write();
        cmd_write = 1'b1; cmd_address = 2'd2; cmd_writedata = 32'h1; cmd_valid = 1'b1;
        sb.push_back({32'h0, 1'b0});
        exp_mem[2] = 32'h1;
        tick();                         // T+1
        cmd_valid = 1'b0;
        total++;
        if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b1, 1'b0, 2'd2, 32'h1}) begin
            bad++;
            $display("FAIL wr_strobe: got cs=%b wn=%b addr=%h wdata=%h want 1 0 2 00000001",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata);
        end
        tick();                         // T+2
        total++;
        if ({avm_chipselect, avm_write_n, rsp_valid, cmd_ready} !== 4'b0110) begin
            bad++;
            $display("FAIL wr_resp_cycle: got cs/wn/rv/rdy=%b want 0110",
                     {avm_chipselect, avm_write_n, rsp_valid, cmd_ready});
        end
        tick();                         // T+3
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL wr_back_idle: got rv/rdy=%b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read();
        cmd_write = 1'b0; cmd_address = 2'd0; cmd_valid = 1'b1;
        sb.push_back({exp_mem[0], 1'b0});
        tick();                         // T+1
        cmd_valid = 1'b0;
        total++;
        if ({avm_chipselect, avm_write_n, cmd_ready} !== 3'b110) begin
            bad++;
            $display("FAIL rd_strobe: got cs/wn/rdy=%b want 110", {avm_chipselect, avm_write_n, cmd_ready});
        end
        tick();                         // T+2 (RWAIT)
        total++;
        if ({avm_chipselect, rsp_valid, avm_address} !== {1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL rd_rwait: got cs=%b rv=%b addr=%h want 0 0 0", avm_chipselect, rsp_valid, avm_address);
        end
        tick();                         // T+3
        total++;
        if ({rsp_valid, rsp_readdata} !== {1'b1, 32'h0000_00A5}) begin
            bad++;
            $display("FAIL rd_resp: got rv=%b data=%h want 1 000000a5", rsp_valid, rsp_readdata);
        end
        tick();
    endtask

    task automatic test_stall_read();
        int cs_cycles = 0;
        logic ready_seen = 1'b0;
        cmd_write = 1'b0; cmd_address = 2'd2; cmd_valid = 1'b1;
        sb.push_back({exp_mem[2], 1'b0});
        tick();                         // T+1
        cmd_valid = 1'b0;
        wait_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin   // T+1 .. T+4
            if (i == 3) wait_req = 1'b0;
            cs_cycles += int'(avm_chipselect);
            ready_seen |= cmd_ready;
            tick();
        end
        total++;                        // T+5
        if (cs_cycles !== 4) begin
            bad++;
            $display("FAIL stall_cs_len: got %0d cycles want 4", cs_cycles);
        end
        total++;
        if ({avm_chipselect, rsp_valid, cmd_ready, ready_seen} !== 4'b0000) begin
            bad++;
            $display("FAIL stall_t5: got cs/rv/rdy/rdy_seen=%b want 0000",
                     {avm_chipselect, rsp_valid, cmd_ready, ready_seen});
        end
        tick();                         // T+6
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b10) begin
            bad++;
            $display("FAIL stall_resp: got rv/rdy=%b want 10", {rsp_valid, cmd_ready});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int base = rsp_seen;
        cmd_write = 1'b1; cmd_address = 2'd3; cmd_writedata = 32'hDEAD_BEEF; cmd_valid = 1'b1;
        sb.push_back({32'h0, 1'b0});
        exp_mem[3] = 32'hDEAD_BEEF;
        sb.push_back({exp_mem[3], 1'b0});
        tick();
        // Next command presented while busy; it must wait, not replace the write.
        cmd_write = 1'b0; cmd_writedata = 32'hFFFF_FFFF;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL b2b_ready_gap: got %0d busy cycles want 2", n);
        end
        tick();
        cmd_valid = 1'b0;
        drain(n);
        tick();
        total++;
        if (rsp_seen - base !== 2 || sb.size() !== 0) begin
            bad++;
            $display("FAIL b2b_rsp_count: got %0d responses (%0d pending) want 2 (0)",
                     rsp_seen - base, sb.size());
        end
    endtask

    task automatic test_irq();
        int rises = 0;
        irq_in = 1'b1;                  // cycle I
        total++;
        if ({irq_level, irq_rise} !== 2'b00) begin
            bad++;
            $display("FAIL irq_before: got lvl/rise=%b want 00", {irq_level, irq_rise});
        end
        tick();                         // I+1
        total++;
        if ({irq_level, irq_rise} !== 2'b11) begin
            bad++;
            $display("FAIL irq_first: got lvl/rise=%b want 11", {irq_level, irq_rise});
        end
        rises += int'(irq_rise);
        for (int i = 0; i < 4; i++) begin   // I+2 .. I+5
            tick();
            if (i == 3) irq_in = 1'b0;
            rises += int'(irq_rise);
            total++;
            if (irq_level !== 1'b1) begin
                bad++;
                $display("FAIL irq_hold: got lvl=%b want 1", irq_level);
            end
        end
        tick();                         // I+6
        total++;
        if ({irq_level, irq_rise} !== 2'b00 || rises !== 1) begin
            bad++;
            $display("FAIL irq_end: got lvl/rise=%b rises=%0d want 00 rises=1", {irq_level, irq_rise}, rises);
        end
    endtask

`ifdef AVM_TIMEOUT_EN
    task automatic test_timeout();
        int cs_cnt = 0;
        int n = 0;
        wait_req = 1'b1;
        cmd_write = 1'b0; cmd_address = 2'd0; cmd_valid = 1'b1;
        sb.push_back({32'h0, 1'b1});
        tick();
        cmd_valid = 1'b0;
        while (avm_chipselect && n < 20) begin
            cs_cnt++;
            tick();
            n++;
        end
        total++;
        if (cs_cnt !== TO || {rsp_valid, rsp_error} !== 2'b11) begin
            bad++;
            $display("FAIL timeout_abort: got cs_cycles=%0d rv/err=%b want %0d 11",
                     cs_cnt, {rsp_valid, rsp_error}, TO);
        end
        wait_req = 1'b0;
        tick();
        cmd_valid = 1'b1;
        sb.push_back({exp_mem[0], 1'b0});
        tick();
        cmd_valid = 1'b0;
        drain(n);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL timeout_recover: %0d responses pending after %0d cycles want 0", sb.size(), n);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        int base;
        cmd_write = 1'b0; cmd_address = 2'd1; cmd_valid = 1'b1;
        tick();                         // T+1
        cmd_valid = 1'b0;
        tick();                         // T+2, RWAIT
        base = rsp_seen;
        reset_n = 1'b0;
        reset_model();
        #1;
        total++;
        if ({cmd_ready, rsp_valid, rsp_error, avm_chipselect, avm_write_n, avm_address} !== {5'b10001, 2'd0}) begin
            bad++;
            $display("FAIL mid_reset_async: got rdy/rv/err/cs/wn=%b addr=%h want 10001 0",
                     {cmd_ready, rsp_valid, rsp_error, avm_chipselect, avm_write_n}, avm_address);
        end
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        total++;
        if (rsp_seen !== base || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_norsp: got %0d responses rdy=%b want 0 1", rsp_seen - base, cmd_ready);
        end
        cmd_valid = 1'b1;
        sb.push_back({exp_mem[1], 1'b0});
        tick();
        cmd_valid = 1'b0;
        drain(n);
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL mid_reset_recover: %0d responses pending after %0d cycles want 0", sb.size(), n);
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_address = '0; cmd_writedata = 32'd0; wait_req = 1'b0; irq_in = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stall_read();
        test_back_to_back();
        test_irq();
`ifdef AVM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL sb_leftover: %0d responses never arrived", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
